// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the FFT input front-end.
//   LANES     : number of register-bank lanes filled per quad
//   state_t   : loader FSM state encoding
//   onehot4() : lane index -> one-hot register-bank write enable
package fft_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_FILL   = 2'd1;
    localparam logic [1:0] ENC_SETTLE = 2'd2;
    localparam logic [1:0] ENC_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ENC_IDLE,
        FILL   = ENC_FILL,
        SETTLE = ENC_SETTLE,
        HOLD   = ENC_HOLD
    } state_t;

    function automatic logic [LANES-1:0] onehot4(input logic [1:0] lane);
        onehot4 = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/fft_quad_loader.sv
// fft_quad_loader
//   Input front-end of the FFT. Takes complex samples over valid/ready,
//   steers each one into a 4-lane register bank, offers each complete quad
//   to the radix-4 butterfly and waits for its acknowledge. Tracks the quad
//   position inside the frame and flags frame misalignment.
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   reset       in   synchronous active-high reset
//   in_valid    in   upstream sample valid
//   in_data     in   complex sample {re, im}, 2*bits wide
//   in_first    in   marks in_data as sample 0 of a frame
//   in_ready    out  loader accepts a sample this cycle
//   rb_enable   out  one-hot register-bank lane write enable (registered)
//   rb_data     out  sample for the register bank (registered)
//   quad_valid  out  register bank holds a complete quad
//   quad_ready  in   butterfly acknowledge, only looked at in HOLD
//   group_idx   out  index of the quad being filled / offered
//   frame_done  out  one-cycle pulse after the last quad of a frame is acked
//   sync_err    out  sticky: in_first seen in the middle of a frame
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for in_first; samples without it are dropped
// FILL     | accepting samples into lanes 0..3 of the current quad
// SETTLE   | lane-3 write is landing in the register bank, no accept
// HOLD     | quad offered to the butterfly until quad_ready
module fft_quad_loader
    import fft_pkg::*;
#(
    parameter int fix_bit = 7,
    parameter int bits    = 16,
    parameter int POINTS  = 32,
    localparam int GROUPS = POINTS / LANES,
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2*bits-1:0] in_data,
    input  logic              in_first,
    output logic              in_ready,
    output logic [LANES-1:0]  rb_enable,
    output logic [2*bits-1:0] rb_data,
    output logic              quad_valid,
    input  logic              quad_ready,
    output logic [GW-1:0]     group_idx,
    output logic              frame_done,
    output logic              sync_err
);

    // fix_bit only describes the number format carried through; it must
    // still make sense for the chosen sample width.
    if (fix_bit < 0 || fix_bit >= bits) begin : g_bad_fix_bit
        $error("fft_quad_loader: fix_bit must lie in [0, bits)");
    end
    if (POINTS < LANES || (POINTS % LANES) != 0) begin : g_bad_points
        $error("fft_quad_loader: POINTS must be a positive multiple of 4");
    end

    state_t              state, state_n;
    logic [1:0]          lane, lane_n;
    logic [GW-1:0]       group_n;
    logic [LANES-1:0]    enable_n;
    logic [2*bits-1:0]   data_n;
    logic                quad_valid_n;
    logic                frame_done_n;
    logic                sync_err_n;
    logic                accept;
    logic                last_group;
    logic                mid_frame;

    assign in_ready   = (state == IDLE) || (state == FILL);
    assign accept     = in_valid & in_ready;
    assign last_group = (group_idx == GW'(GROUPS - 1));
    // In FILL, lane 0 of group 0 is the only position where in_first is
    // legal; IDLE always leaves with lane 1 so this mostly catches re-starts.
    assign mid_frame  = (lane != 2'd0) || (group_idx != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= 2'd0;
            group_idx  <= '0;
            rb_enable  <= '0;
            rb_data    <= '0;
            quad_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            group_idx  <= group_n;
            rb_enable  <= enable_n;
            rb_data    <= data_n;
            quad_valid <= quad_valid_n;
            frame_done <= frame_done_n;
            sync_err   <= sync_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        lane_n       = lane;
        group_n      = group_idx;
        enable_n     = '0;
        data_n       = rb_data;
        quad_valid_n = quad_valid;
        frame_done_n = 1'b0;
        sync_err_n   = sync_err;

        case (state)
            IDLE: begin
                if (accept && in_first) begin
                    enable_n = onehot4(2'd0);
                    data_n   = in_data;
                    lane_n   = 2'd1;
                    group_n  = '0;
                    state_n  = FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    data_n = in_data;
                    if (in_first && mid_frame) begin
                        // Realign on the new frame; lanes already written for
                        // the abandoned quad are simply overwritten later.
                        sync_err_n = 1'b1;
                        enable_n   = onehot4(2'd0);
                        lane_n     = 2'd1;
                        group_n    = '0;
                    end else begin
                        enable_n = onehot4(lane);
                        if (lane == 2'd3) begin
                            lane_n  = 2'd0;
                            state_n = SETTLE;
                        end else begin
                            lane_n = lane + 2'd1;
                        end
                    end
                end
            end

            SETTLE: begin
                state_n      = HOLD;
                quad_valid_n = 1'b1;
            end

            HOLD: begin
                if (quad_ready) begin
                    quad_valid_n = 1'b0;
                    if (last_group) begin
                        frame_done_n = 1'b1;
                        group_n      = '0;
                        state_n      = IDLE;
                    end else begin
                        group_n = group_idx + GW'(1);
                        state_n = FILL;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_quad_loader.sv
// tb_fft_quad_loader
//   Self-checking bench for fft_quad_loader. A behavioural model counts
//   accepted samples per frame and derives the expected handshake and
//   register-bank activity from that count.
module tb_fft_quad_loader;

    localparam int POINTS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_first;
    logic        in_ready;
    logic [3:0]  rb_enable;
    logic [31:0] rb_data;
    logic        quad_valid;
    logic        quad_ready;
    logic [2:0]  group_idx;
    logic        frame_done;
    logic        sync_err;

    int checks = 0;
    int errors = 0;

    fft_quad_loader #(.fix_bit(7), .bits(16), .POINTS(POINTS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_first   (in_first),
        .in_ready   (in_ready),
        .rb_enable  (rb_enable),
        .rb_data    (rb_data),
        .quad_valid (quad_valid),
        .quad_ready (quad_ready),
        .group_idx  (group_idx),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: m_pos = samples taken in the current frame.
    int          m_pos    = 0;
    bit          m_active = 1'b0;
    bit          m_settle = 1'b0;
    bit          m_offer  = 1'b0;
    logic [3:0]  exp_en   = '0;
    logic [31:0] exp_data = '0;
    logic        exp_fd   = 1'b0;
    logic        exp_err  = 1'b0;
    logic        exp_ready;
    logic [2:0]  exp_grp;
    logic [10:0] obs_vec;
    logic [10:0] exp_vec;

    always @(posedge clk) begin
        exp_en <= '0;
        exp_fd <= 1'b0;
        if (reset) begin
            m_pos    <= 0;
            m_active <= 1'b0;
            m_settle <= 1'b0;
            m_offer  <= 1'b0;
            exp_data <= '0;
            exp_err  <= 1'b0;
        end else if (m_settle) begin
            m_settle <= 1'b0;
            m_offer  <= 1'b1;
        end else if (m_offer) begin
            if (quad_ready) begin
                m_offer <= 1'b0;
                if (m_pos == POINTS) begin
                    m_pos    <= 0;
                    m_active <= 1'b0;
                    exp_fd   <= 1'b1;
                end
            end
        end else if (in_valid) begin
            if (in_first) begin
                if (m_active) exp_err <= 1'b1;
                m_active <= 1'b1;
                m_pos    <= 1;
                exp_en   <= 4'b0001;
                exp_data <= in_data;
            end else if (m_active) begin
                exp_en   <= 4'b0001 << (m_pos % 4);
                exp_data <= in_data;
                m_pos    <= m_pos + 1;
                if (m_pos % 4 == 3) m_settle <= 1'b1;
            end
        end
    end

    always_comb begin
        exp_ready = !m_settle && !m_offer;
        if (m_settle || m_offer) exp_grp = 3'(m_pos / 4 - 1);
        else                     exp_grp = 3'(m_pos / 4);
    end

    assign obs_vec = {in_ready, quad_valid, group_idx, rb_enable, frame_done, sync_err};
    assign exp_vec = {exp_ready, m_offer, exp_grp, exp_en, exp_fd, exp_err};

    task automatic drive(input logic v, input logic f, input logic [31:0] d, input logic qr);
        in_valid   = v;
        in_first   = f;
        in_data    = d;
        quad_ready = qr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, $urandom, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (rb_enable !== 4'b0000) begin errors++; $display("FAIL reset_rb_enable got %b want 0000", rb_enable); end
        checks++; if (rb_data !== 32'h0) begin errors++; $display("FAIL reset_rb_data got %h want 0", rb_data); end
        checks++; if (quad_valid !== 1'b0) begin errors++; $display("FAIL reset_quad_valid got %b want 0", quad_valid); end
        checks++; if (group_idx !== 3'd0) begin errors++; $display("FAIL reset_group_idx got %0d want 0", group_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checks++; if (rb_enable !== 4'b0000) begin errors++; $display("FAIL post_reset_rb_enable got %b want 0000", rb_enable); end
    endtask

    task automatic test_full_frame();
        int idx = 0;
        int qv_rises = 0;
        int fd_cnt = 0;
        logic prev_qv = 1'b0;
        logic [3:0]  en_q[$];
        logic [31:0] d_q[$];
        logic [2:0]  g_q[$];
        for (int cyc = 0; cyc < 70; cyc++) begin
            logic adv;
            drive(idx < 32, idx == 0, 32'(idx) << 16, 1'b1);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) idx++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL frame_model t=%0t got %b want %b", $time, obs_vec, exp_vec); end
            if (exp_en != 4'b0000) begin
                checks++;
                if (rb_data !== exp_data) begin errors++; $display("FAIL frame_model_data got %h want %h", rb_data, exp_data); end
            end
            if (rb_enable != 4'b0000) begin en_q.push_back(rb_enable); d_q.push_back(rb_data); end
            if (quad_valid && !prev_qv) begin qv_rises++; g_q.push_back(group_idx); end
            prev_qv = quad_valid;
            if (frame_done) fd_cnt++;
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        checks++; if (en_q.size() != 32) begin errors++; $display("FAIL frame_write_count got %0d want 32", en_q.size()); end
        for (int i = 0; i < en_q.size() && i < 32; i++) begin
            checks++;
            if (en_q[i] !== 4'(1 << (i % 4)) || d_q[i] !== (32'(i) << 16)) begin
                errors++;
                $display("FAIL frame_write_%0d got en=%b data=%h want en=%b data=%h", i, en_q[i], d_q[i], 4'(1 << (i % 4)), 32'(i) << 16);
            end
        end
        checks++; if (qv_rises != 8) begin errors++; $display("FAIL frame_quad_count got %0d want 8", qv_rises); end
        for (int i = 0; i < g_q.size(); i++) begin
            checks++; if (g_q[i] !== 3'(i)) begin errors++; $display("FAIL frame_group_%0d got %0d want %0d", i, g_q[i], i); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", fd_cnt); end
    endtask

    task automatic test_hold_stall();
        int n = 0;
        logic [31:0] d;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            logic adv;
            drive(1'b1, n == 0, $urandom, 1'b0);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) n++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_load t=%0t got %b want %b", $time, obs_vec, exp_vec); end
        end
        for (int k = 0; k < 5 && !quad_valid; k++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
        end
        checks++; if (quad_valid !== 1'b1) begin errors++; $display("FAIL stall_offer_timeout got %b want 1", quad_valid); end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || quad_valid !== 1'b1 || group_idx !== 3'd0) begin
                errors++;
                $display("FAIL stall_hold_%0d got ready=%b qv=%b grp=%0d want ready=0 qv=1 grp=0", k, in_ready, quad_valid, group_idx);
            end
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_hold_model got %b want %b", obs_vec, exp_vec); end
        end
        drive(1'b1, 1'b0, $urandom, 1'b1);
        @(negedge clk);
        checks++;
        if (quad_valid !== 1'b0 || in_ready !== 1'b1 || group_idx !== 3'd1) begin
            errors++;
            $display("FAIL stall_ack got qv=%b ready=%b grp=%0d want qv=0 ready=1 grp=1", quad_valid, in_ready, group_idx);
        end
        d = $urandom;
        drive(1'b1, 1'b0, d, 1'b0);
        @(negedge clk);
        checks++;
        if (rb_enable !== 4'b0001 || rb_data !== d) begin
            errors++;
            $display("FAIL stall_resume got en=%b data=%h want en=0001 data=%h", rb_enable, rb_data, d);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_idle_drop();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            @(negedge clk);
            checks++;
            if (rb_enable !== 4'b0000 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_drop_%0d got en=%b ready=%b want en=0000 ready=1", k, rb_enable, in_ready);
            end
        end
        drive(1'b1, 1'b1, 32'hABCD_1234, 1'b0);
        @(negedge clk);
        checks++;
        if (rb_enable !== 4'b0001 || rb_data !== 32'hABCD_1234 || group_idx !== 3'd0) begin
            errors++;
            $display("FAIL idle_first got en=%b data=%h grp=%0d want en=0001 data=abcd1234 grp=0", rb_enable, rb_data, group_idx);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checks++; if (rb_enable !== 4'b0000) begin errors++; $display("FAIL idle_after got en=%b want 0000", rb_enable); end
    endtask

    task automatic test_sync_err();
        int n = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 120 && n < 14; cyc++) begin
            logic adv;
            drive(1'b1, n == 0, $urandom, 1'b1);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) n++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL sync_load t=%0t got %b want %b", $time, obs_vec, exp_vec); end
        end
        checks++;
        if (n != 14 || group_idx !== 3'd3 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_pre got n=%0d grp=%0d err=%b want n=14 grp=3 err=0", n, group_idx, sync_err);
        end
        drive(1'b1, 1'b1, 32'h5A5A_C3C3, 1'b1);
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b1 || rb_enable !== 4'b0001 || rb_data !== 32'h5A5A_C3C3 || group_idx !== 3'd0) begin
            errors++;
            $display("FAIL sync_realign got err=%b en=%b data=%h grp=%0d want err=1 en=0001 data=5a5ac3c3 grp=0",
                     sync_err, rb_enable, rb_data, group_idx);
        end
        for (int k = 0; k < 30; k++) begin
            drive(1'($urandom % 2), 1'b0, $urandom, 1'($urandom % 2));
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL sync_after t=%0t got %b want %b", $time, obs_vec, exp_vec); end
        end
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky got %b want 1", sync_err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_cleared got %b want 0", sync_err); end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        int n = 0;
        int fd_cnt = 0;
        int writes = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            logic adv;
            drive(1'b1, n == 0, $urandom, 1'b0);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) n++;
        end
        for (int k = 0; k < 5 && !quad_valid; k++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
        end
        checks++; if (quad_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_offer got %b want 1", quad_valid); end
        reset = 1'b1;
        drive(1'b1, 1'b1, $urandom, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({rb_enable, rb_data, quad_valid, group_idx, frame_done, sync_err} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_clear got en=%b data=%h qv=%b grp=%0d fd=%b err=%b ready=%b want all 0 ready=1",
                     rb_enable, rb_data, quad_valid, group_idx, frame_done, sync_err, in_ready);
        end
        n = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            logic adv;
            drive(n < 32, n == 0, $urandom, 1'b1);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) n++;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL rst_hold_frame t=%0t got %b want %b", $time, obs_vec, exp_vec); end
            if (exp_en != 4'b0000) begin
                checks++;
                if (rb_data !== exp_data) begin errors++; $display("FAIL rst_hold_data got %h want %h", rb_data, exp_data); end
            end
            if (rb_enable != 4'b0000) writes++;
            if (frame_done) fd_cnt++;
        end
        checks++;
        if (writes != 32 || fd_cnt != 1) begin
            errors++;
            $display("FAIL rst_hold_reload got writes=%0d done=%0d want writes=32 done=1", writes, fd_cnt);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_toggle_valid();
        int idx = 0;
        int last4 = -10;
        int hits = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            logic adv;
            drive((cyc % 2 == 0) && idx < 32, idx == 0, $urandom, 1'b1);
            adv = in_valid && in_ready;
            @(negedge clk);
            if (adv) begin
                idx++;
                if (idx % 4 == 0) last4 = cyc;
            end
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL toggle_model t=%0t got %b want %b", $time, obs_vec, exp_vec); end
            if (exp_en != 4'b0000) begin
                checks++;
                if (rb_data !== exp_data) begin errors++; $display("FAIL toggle_data got %h want %h", rb_data, exp_data); end
            end
            if (cyc == last4) begin
                checks++;
                if (quad_valid !== 1'b0 || rb_enable !== 4'b1000) begin
                    errors++;
                    $display("FAIL toggle_settle got qv=%b en=%b want qv=0 en=1000", quad_valid, rb_enable);
                end
            end
            if (cyc == last4 + 1) begin
                checks++;
                if (quad_valid !== 1'b1) begin errors++; $display("FAIL toggle_latency got qv=%b want 1", quad_valid); end
                else hits++;
            end
        end
        checks++;
        if (idx != 32 || hits != 8) begin
            errors++;
            $display("FAIL toggle_totals got samples=%0d quads=%0d want samples=32 quads=8", idx, hits);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 149) == 0);
            drive(($urandom % 4) != 0,
                  (!m_active && ($urandom % 3 == 0)) || ($urandom % 60 == 0),
                  $urandom,
                  ($urandom % 3) != 0);
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_model t=%0t got %b want %b", $time, obs_vec, exp_vec); end
            if (exp_en != 4'b0000) begin
                checks++;
                if (rb_data !== exp_data) begin errors++; $display("FAIL random_data got %h want %h", rb_data, exp_data); end
            end
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        test_reset();
        test_full_frame();
        test_hold_stall();
        test_idle_drop();
        test_sync_err();
        test_reset_in_hold();
        test_toggle_valid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
